// File: rtl/lz77_job_ctrl_pkg.sv
// Shared types and constants for the LZ77 encoder job controller.
package lz77_job_ctrl_pkg;

  localparam int unsigned OFF_W       = 4;
  localparam int unsigned LEN_W       = 3;
  localparam int unsigned CHR_W       = 8;
  localparam int unsigned TOK_W       = OFF_W + LEN_W + CHR_W;
  localparam int unsigned CNT_W       = 12;
  localparam int unsigned N_CHARS_DEF = 2048;
  localparam logic [CHR_W-1:0] TERM_CHAR = 8'h24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENC_RST,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [OFF_W-1:0] offset;
    logic [LEN_W-1:0] match_len;
    logic [CHR_W-1:0] char_nxt;
  } tok_t;

  // Two-source round-robin: on a tie the source not granted last time wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/lz77_tok_fifo.sv
// Synchronous token FIFO; push while full is accepted only when a pop frees a slot.
module lz77_tok_fifo
  import lz77_job_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  tok_t wdata_i,
  output tok_t rdata_o,
  output logic full_o,
  output logic empty_o,
  output logic one_left_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  tok_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign one_left_o = (count_q == CW'(1));
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign rdata_o    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lz77_job_ctrl.sv
// Arbitrates two character sources onto one LZ77 encoder and buffers its tokens.
module lz77_job_ctrl
  import lz77_job_ctrl_pkg::*;
#(
  parameter int unsigned N_CHARS    = N_CHARS_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       src_req,
  input  logic [CHR_W-1:0] src_data0,
  input  logic [CHR_W-1:0] src_data1,
  input  logic [1:0]       src_valid,
  output logic [1:0]       src_ready,
  output logic [1:0]       grant,
  output logic             enc_reset,
  output logic [CHR_W-1:0] enc_chardata,
  input  logic             enc_valid,
  input  logic [OFF_W-1:0] enc_offset,
  input  logic [LEN_W-1:0] enc_match_len,
  input  logic [CHR_W-1:0] enc_char_nxt,
  input  logic             enc_finish,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [TOK_W-1:0] tok_data,
  output logic             tok_src,
  output logic             done,
  output logic             err_underrun,
  output logic             err_overflow
);

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic             src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enc_rst_q, enc_rst_d;
  logic             done_q, done_d;
  logic             under_q, under_d;
  logic             over_q, over_d;

  logic             pick;
  logic             in_load;
  logic             cur_valid;
  logic [CHR_W-1:0] cur_data;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_one;
  tok_t             push_tok;
  tok_t             head_tok;

  assign pick      = rr_pick(src_req, last_q);
  assign in_load   = (state_q == ST_LOAD);
  assign cur_valid = src_q ? src_valid[1] : src_valid[0];
  assign cur_data  = src_q ? src_data1 : src_data0;

  // Encoder cannot stall: a missing character is replaced by zero.
  assign src_ready    = in_load ? grant_q : 2'b00;
  assign enc_chardata = (in_load && cur_valid) ? cur_data : '0;

  assign push      = (state_q == ST_RUN) && enc_valid;
  assign pop       = tok_valid && tok_ready;
  assign push_tok  = {enc_offset, enc_match_len, enc_char_nxt};
  assign tok_valid = ~fifo_empty;
  assign tok_data  = head_tok;

  assign grant        = grant_q;
  assign enc_reset    = enc_rst_q;
  assign tok_src      = src_q;
  assign done         = done_q;
  assign err_underrun = under_q;
  assign err_overflow = over_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= 1'b1;
      src_q     <= 1'b0;
      cnt_q     <= '0;
      enc_rst_q <= 1'b1;
      done_q    <= 1'b0;
      under_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      src_q     <= src_d;
      cnt_q     <= cnt_d;
      enc_rst_q <= enc_rst_d;
      done_q    <= done_d;
      under_q   <= under_d;
      over_q    <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    under_d = under_q;
    over_d  = over_q;

    case (state_q)
      ST_IDLE: begin
        if (src_req != 2'b00) begin
          grant_d = pick ? 2'b10 : 2'b01;
          src_d   = pick;
          last_d  = pick;
          state_d = ST_ENC_RST;
        end
      end
      ST_ENC_RST: begin
        under_d = 1'b0;
        over_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!cur_valid) under_d = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_CHARS - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (enc_valid && fifo_full && !pop) over_d = 1'b1;
        if (enc_finish) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty || (fifo_one && pop)) state_d = ST_DONE;
      end
      ST_DONE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    enc_rst_d = (state_d == ST_ENC_RST);
    done_d    = (state_d == ST_DONE);
  end

  lz77_tok_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   (push_tok),
    .rdata_o   (head_tok),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .one_left_o(fifo_one)
  );

endmodule

// File: tb/tb_lz77_job_ctrl.sv
// Directed jobs driven into the controller; a monitor scores tokens against a queue.
module tb_lz77_job_ctrl;
  import lz77_job_ctrl_pkg::*;

  localparam int NCH   = 2048;
  localparam int DEPTH = 4;
  localparam int NONE  = NCH + 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  src_req;
  logic [7:0]  src_data0, src_data1;
  logic [1:0]  src_valid;
  logic [1:0]  src_ready;
  logic [1:0]  grant;
  logic        enc_reset;
  logic [7:0]  enc_chardata;
  logic        enc_valid;
  logic [3:0]  enc_offset;
  logic [2:0]  enc_match_len;
  logic [7:0]  enc_char_nxt;
  logic        enc_finish;
  logic        tok_valid;
  logic        tok_ready;
  logic [14:0] tok_data;
  logic        tok_src;
  logic        done;
  logic        err_underrun, err_overflow;

  always #5 clk = ~clk;

  lz77_job_ctrl #(.N_CHARS(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .src_req(src_req), .src_data0(src_data0), .src_data1(src_data1),
    .src_valid(src_valid), .src_ready(src_ready), .grant(grant), .enc_reset(enc_reset),
    .enc_chardata(enc_chardata), .enc_valid(enc_valid), .enc_offset(enc_offset),
    .enc_match_len(enc_match_len), .enc_char_nxt(enc_char_nxt), .enc_finish(enc_finish),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data), .tok_src(tok_src),
    .done(done), .err_underrun(err_underrun), .err_overflow(err_overflow)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_tok_seen = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic        stall_q = 1'b0;
  logic [14:0] stall_data;
  bit          tog = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expected token on every accepted transfer.
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && tok_valid) check("tok_data_stable", 32'(tok_data), 32'(stall_data));
      if (tok_valid && tok_ready) begin
        n_tok_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tok_unexpected: got %0h expected none at %0t", tok_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("tok_data", 32'(tok_data), 32'(mon_e[14:0]));
          check("tok_src", 32'(tok_src), 32'(mon_e[15]));
        end
      end
      stall_q    = tok_valid && !tok_ready;
      stall_data = tok_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (tog) tok_ready = ~tok_ready;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_src_ready"}, 32'(src_ready), 0);
    check({tag, "_enc_reset"}, 32'(enc_reset), 1);
    check({tag, "_enc_chardata"}, 32'(enc_chardata), 0);
    check({tag, "_tok_valid"}, 32'(tok_valid), 0);
    check({tag, "_tok_data"}, 32'(tok_data), 0);
    check({tag, "_tok_src"}, 32'(tok_src), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_errs"}, 32'({err_underrun, err_overflow}), 0);
  endtask

  task automatic do_abort();
    #1 reset = 1'b1;
    #1;
    check_reset_vals("abort");
    exp_q.delete();
    @(posedge clk);
    #2;
    check_reset_vals("abort_clk");
    reset     = 1'b0;
    src_valid = 2'b00;
    step();
    check("enc_reset_fall", 32'(enc_reset), 0);
    check("grant_after_rst", 32'(grant), 0);
  endtask

  task automatic run_job(input logic [1:0] req, input logic [1:0] exp_gnt, input int drop_at,
                         input int ntok, input int gap, input bit hold, input bit toggle,
                         input bit exp_under, input bit exp_over, input int abort_at);
    logic       idx;
    logic [7:0] gdata;
    logic [7:0] exp_c;
    bit         got_done;
    bit         in_drop;
    idx        = exp_gnt[1];
    n_tok_seen = 0;
    tok_ready  = 1'b1;
    tog        = 1'b0;
    src_req    = req;
    step();
    check("grant", 32'(grant), 32'(exp_gnt));
    check("enc_reset_hi", 32'(enc_reset), 1);
    check("tok_src_job", 32'(tok_src), 32'(idx));
    src_req = 2'b00;
    step();
    check("enc_reset_lo", 32'(enc_reset), 0);
    check("err_cleared", 32'({err_underrun, err_overflow}), 0);
    gdata = idx ? src_data1 : src_data0;
    for (int i = 0; i < NCH; i++) begin
      in_drop   = (i >= drop_at) && (i < drop_at + 3);
      src_valid = 2'b11;
      if (in_drop) src_valid[idx] = 1'b0;
      #1;
      exp_c = in_drop ? 8'h00 : gdata;
      check("src_ready", 32'(src_ready), 32'(exp_gnt));
      check("enc_chardata", 32'(enc_chardata), 32'(exp_c));
      if (i == abort_at) begin
        do_abort();
        return;
      end
      step();
    end
    src_valid = 2'b00;
    #1;
    check("load_end_ready", 32'(src_ready), 0);
    if (hold) tok_ready = 1'b0;
    tog = toggle;
    for (int k = 0; k < ntok; k++) begin
      enc_valid     = 1'b1;
      enc_offset    = 4'(k + 1);
      enc_match_len = 3'(k);
      enc_char_nxt  = 8'(8'h30 + k);
      if (!(hold && k >= DEPTH)) exp_q.push_back({idx, enc_offset, enc_match_len, enc_char_nxt});
      step();
      enc_valid = 1'b0;
      for (int g = 1; g < gap; g++) step();
    end
    enc_finish = 1'b1;
    step();
    enc_finish = 1'b0;
    if (hold) begin
      check("err_overflow_run", 32'(err_overflow), 1);
      check("tok_valid_held", 32'(tok_valid), 1);
      tok_ready = 1'b1;
    end
    got_done = 1'b0;
    for (int w = 0; w < 64 && !got_done; w++) begin
      if (done) got_done = 1'b1;
      else step();
    end
    check("done_seen", 32'(got_done), 1);
    check("err_underrun", 32'(err_underrun), 32'(exp_under));
    check("err_overflow", 32'(err_overflow), 32'(exp_over));
    check("tok_count", 32'(n_tok_seen), 32'(hold ? DEPTH : ntok));
    check("tok_drained", 32'(exp_q.size()), 0);
    tog       = 1'b0;
    tok_ready = 1'b1;
    step();
    check("done_pulse", 32'(done), 0);
    check("grant_idle", 32'(grant), 0);
  endtask

  initial begin
    reset         = 1'b1;
    src_req       = 2'b00;
    src_data0     = 8'h41;
    src_data1     = 8'h5A;
    src_valid     = 2'b00;
    enc_valid     = 1'b0;
    enc_offset    = '0;
    enc_match_len = '0;
    enc_char_nxt  = '0;
    enc_finish    = 1'b0;
    tok_ready     = 1'b1;
    #12;
    check_reset_vals("por");
    @(posedge clk);
    #2;
    reset = 1'b0;
    step();
    check("enc_reset_first_clk", 32'(enc_reset), 0);

    // Tie from reset goes to source 0, clean "AAAA" job.
    run_job(2'b11, 2'b01, NONE, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    // Tie again: source 1, with a three-character gap at char 100.
    run_job(2'b11, 2'b10, 100, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    // Tie again: source 0, five tokens against a stalled sink.
    run_job(2'b11, 2'b01, NONE, 5, 1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    // Source 1 alone, sink ready toggling.
    run_job(2'b10, 2'b10, NONE, 6, 3, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    // Source 1 job aborted by reset at char 1000 after an underrun.
    run_job(2'b10, 2'b10, 100, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1000);
    // Reset restored source 0 priority.
    run_job(2'b11, 2'b01, NONE, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lz77_job_ctrl.md
LZ77_JOB_CTRL -- requirements
Module: lz77_job_ctrl

Interface
REQ-001 Parameter N_CHARS, default 2048, meaning characters per encoder job.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning output token FIFO entries (power of two).
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 src_req  input  2  per-source job request, level, held until grant.
REQ-006 src_data0 / src_data1  input  8  per-source character stream.
REQ-007 src_valid  input  2  per-source character valid.
REQ-008 src_ready  output  2  per-source character accept, one-hot or zero.
REQ-009 grant  output  2  one-hot owner of current job, zero when idle.
REQ-010 enc_reset  output  1  synchronous restart pulse to encoder.
REQ-011 enc_chardata  output  8  character to encoder.
REQ-012 enc_valid  input  1  encoder token strobe, single cycle, not stallable.
REQ-013 enc_offset / enc_match_len / enc_char_nxt  input  4 / 3 / 8  encoder token fields.
REQ-014 enc_finish  input  1  encoder end-of-job flag.
REQ-015 tok_valid  output  1  downstream token valid.
REQ-016 tok_ready  input  1  downstream token accept.
REQ-017 tok_data  output  15  {offset[14:11], match_len[10:8], char_nxt[7:0]}.
REQ-018 tok_src  output  1  index of source owning tok_data.
REQ-019 done  output  1  one-cycle job-complete pulse.
REQ-020 err_underrun / err_overflow  output  1 / 1  sticky error flags, cleared at next job start.

Function
REQ-021 FSM states: IDLE, ENC_RST, LOAD, RUN, DRAIN, DONE.
REQ-022 IDLE: if src_req!=0, grant per round-robin, go ENC_RST; else stay.
REQ-023 Round-robin: last-granted source has lowest priority; after reset source 0 has priority; simultaneous requests resolved by this rule.
REQ-024 ENC_RST: enc_reset=1 exactly one cycle, clear error flags, load counter 0, go LOAD.
REQ-025 LOAD: exactly N_CHARS cycles; src_ready = grant; enc_chardata = granted source data, combinational pass-through.
REQ-026 LOAD with granted src_valid=0: enc_chardata=8'h00, err_underrun set, counter still advances (encoder cannot stall).
REQ-027 LOAD exit when counter==N_CHARS-1, go RUN; counter is 12 bits, no wrap within a job.
REQ-028 RUN: every enc_valid cycle pushes token to FIFO; on enc_finish go DRAIN.
REQ-029 FIFO full on enc_valid: token dropped, err_overflow set; simultaneous pop and push when full: push accepted.
REQ-030 tok_valid = FIFO non-empty; pop when tok_valid & tok_ready; tok_data stable while tok_valid & !tok_ready.
REQ-031 DRAIN: wait FIFO empty (including pop this cycle), go DONE.
REQ-032 DONE: done=1 one cycle, grant cleared, go IDLE; request deassertion mid-job ignored.
REQ-033 tok_src = owner recorded at ENC_RST, constant for the job.

Reset
REQ-034 Reset asserted at any time: state IDLE, FIFO emptied, RR pointer to source 0, abort current job.
REQ-035 Reset values: grant=0, src_ready=0, enc_reset=1 (encoder held in reset), enc_chardata=0, tok_valid=0, tok_data=0, tok_src=0, done=0, err flags=0.
REQ-036 enc_reset falls to 0 on first clock after reset deasserts.

Structure
REQ-037 Shared package holds FSM state enum, token field widths, N_CHARS default, '$' terminator 8'h24.
REQ-038 Sub-module lz77_tok_fifo: synchronous FIFO, width 15, depth FIFO_DEPTH, full/empty flags.

Verification
REQ-039 src_req=2'b01, 2048 valid chars "AAAA..." -> grant=01, enc_reset one cycle, LOAD 2048 cycles, tokens out, done pulse, no errors.
REQ-040 src_req=2'b11 from reset -> source 0 first, source 1 next job; repeat -> source 0 third.
REQ-041 src_valid drops 3 cycles at char 100 -> enc_chardata=0 those cycles, err_underrun=1, job completes.
REQ-042 tok_ready=0 throughout RUN with 5 tokens -> 4 stored, err_overflow=1, first 4 emitted in order after release.
REQ-043 tok_ready toggling 1/0 -> tok_data stable while stalled, token count matches enc_valid count.
REQ-044 reset asserted mid-LOAD at char 1000 -> all outputs at reset values next cycle, new request starts cleanly.
